// File: rtl/fp_pkg.sv
// Shared definitions for the sequential divider: field widths, bias, canonical qNaN,
// operand classification helpers and the FSM state type.
package fp_pkg;

  localparam int unsigned FP_NEXP  = 8;
  localparam int unsigned FP_NSIG  = 7;
  localparam int unsigned FP_WIDTH = 1 + FP_NEXP + FP_NSIG;
  localparam int unsigned BIAS     = 2 ** (FP_NEXP - 1) - 1;

  localparam logic [FP_NEXP-1:0]  EXP_MAX = '1;
  localparam logic [FP_WIDTH-1:0] QNAN    = {1'b0, EXP_MAX, 1'b1, {(FP_NSIG - 1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StRecip, StMul, StNorm, StDone} state_e;

  // Subnormals are flushed: a zero exponent alone means zero.
  function automatic logic is_zero(input logic [FP_NEXP-1:0] e);
    return e == '0;
  endfunction

  function automatic logic is_inf(input logic [FP_NEXP-1:0] e, input logic [FP_NSIG-1:0] f);
    return (e == EXP_MAX) && (f == '0);
  endfunction

  function automatic logic is_nan(input logic [FP_NEXP-1:0] e, input logic [FP_NSIG-1:0] f);
    return (e == EXP_MAX) && (f != '0);
  endfunction

endpackage

// File: rtl/fp_nr_step.sv
// One combinational Newton-Raphson reciprocal step: x_next = x * (2 - m_b * x).
// m_b is Q1.NSIG, x and x_next are Q1.(NSIG+GUARD); both products are truncated.
module fp_nr_step #(
  parameter int unsigned NSIG  = 7,
  parameter int unsigned GUARD = 8
) (
  input  logic [NSIG:0]       m_b,
  input  logic [NSIG+GUARD:0] x,
  output logic [NSIG+GUARD:0] x_next
);

  localparam int unsigned F = NSIG + GUARD;
  localparam logic [F+1:0] TWO = {2'b10, {F{1'b0}}};

  logic [NSIG+F+1:0] mx;
  logic [F+1:0]      t;
  logic [F+1:0]      d;
  logic [2*F+2:0]    xd;
  logic              unused_bits;

  always_comb begin
    mx     = {{(F + 1){1'b0}}, m_b} * {{(NSIG + 1){1'b0}}, x};
    t      = mx[NSIG+F+1:NSIG];
    d      = TWO - t;
    xd     = {{(F + 2){1'b0}}, x} * {{(F + 1){1'b0}}, d};
    // x never exceeds 1.0, so the integer bits above Q1 are always zero.
    x_next = xd[2*F:F];
  end

  assign unused_bits = ^{mx[NSIG-1:0], xd[2*F+2:2*F+1], xd[F-1:0]};

endmodule

// File: rtl/fp_div_seq.sv
// Multi-cycle FP divider Q = A / B: NR reciprocal of m_B, multiply by m_A, normalise, pack.
// Define FPDIV_RNE_ROUND_EN for round-to-nearest-even; the default build truncates.
module fp_div_seq
  import fp_pkg::*;
#(
  parameter int unsigned NEXP  = FP_NEXP,
  parameter int unsigned NSIG  = FP_NSIG,
  parameter int unsigned NITER = 3,
  parameter int unsigned GUARD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NEXP+NSIG:0]   in_a,
  input  logic [NEXP+NSIG:0]   in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NEXP+NSIG:0]   out_q,
  output logic                 out_dbz
);

  localparam int unsigned F  = NSIG + GUARD;
  localparam int unsigned XW = F + 1;
  localparam int unsigned PW = NSIG + F + 2;
  localparam int unsigned EW = NEXP + 2;
  localparam int unsigned CW = (NITER > 1) ? $clog2(NITER) : 1;
  localparam logic [XW-1:0] THREE_HALF = XW'(3) << (F - 1);

  state_e state_q, state_d;

  logic                sign_q, sign_d;
  logic [NEXP-1:0]     ea_q, ea_d, eb_q, eb_d;
  logic [NSIG:0]       ma_q, ma_d, mb_q, mb_d;
  logic [XW-1:0]       x_q, x_d, x_next;
  logic [PW-1:0]       p_q, p_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NEXP+NSIG:0]  q_q, q_d;
  logic                dbz_q, dbz_d;

  logic [NEXP-1:0]     exp_a, exp_b;
  logic [NSIG-1:0]     frac_a, frac_b;
  logic                zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic                special, sign_in, last_iter;
  logic [NEXP+NSIG:0]  spec_q;
  logic                spec_dbz;

  assign exp_a     = in_a[NEXP+NSIG-1:NSIG];
  assign exp_b     = in_b[NEXP+NSIG-1:NSIG];
  assign frac_a    = in_a[NSIG-1:0];
  assign frac_b    = in_b[NSIG-1:0];
  assign zero_a    = is_zero(exp_a);
  assign zero_b    = is_zero(exp_b);
  assign inf_a     = is_inf(exp_a, frac_a);
  assign inf_b     = is_inf(exp_b, frac_b);
  assign nan_a     = is_nan(exp_a, frac_a);
  assign nan_b     = is_nan(exp_b, frac_b);
  assign special   = zero_a | zero_b | inf_a | inf_b | nan_a | nan_b;
  assign sign_in   = in_a[NEXP+NSIG] ^ in_b[NEXP+NSIG];
  assign last_iter = cnt_q == CW'(NITER - 1);

  // Special-operand results, highest priority first.
  always_comb begin
    spec_q   = {sign_in, {(NEXP + NSIG){1'b0}}};
    spec_dbz = 1'b0;
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
      spec_q = QNAN;
    end else if (zero_b && !inf_a) begin
      spec_q   = {sign_in, EXP_MAX, {NSIG{1'b0}}};
      spec_dbz = 1'b1;
    end else if (inf_a) begin
      spec_q = {sign_in, EXP_MAX, {NSIG{1'b0}}};
    end
  end

  fp_nr_step #(
    .NSIG  (NSIG),
    .GUARD (GUARD)
  ) u_nr_step (
    .m_b    (mb_q),
    .x      (x_q),
    .x_next (x_next)
  );

  // Normalisation, optional rounding and range check of the registered product.
  logic signed [EW-1:0] e_norm;
  logic [PW-1:0]        pn;
  logic [NSIG-1:0]      frac_n;
  logic [NEXP+NSIG:0]   norm_q;
  logic                 unused_pn;
`ifdef FPDIV_RNE_ROUND_EN
  logic                 rnd_up;
  logic                 carry;
`endif

  always_comb begin
    e_norm = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + $signed(EW'(BIAS));
    pn     = p_q;
    if (p_q[PW-1:PW-2] == 2'b00) begin
      pn     = p_q << 1;
      e_norm = e_norm - $signed(EW'(1));
    end
    frac_n = pn[PW-3 -: NSIG];
`ifdef FPDIV_RNE_ROUND_EN
    rnd_up = pn[F-1] && (pn[F-2] || (|pn[F-3:0]) || frac_n[0]);
    {carry, frac_n} = {1'b0, frac_n} + (NSIG + 1)'(rnd_up);
    if (carry) begin
      e_norm = e_norm + $signed(EW'(1));
    end
`endif
    if (e_norm >= $signed({2'b00, EXP_MAX})) begin
      norm_q = {sign_q, EXP_MAX, {NSIG{1'b0}}};
    end else if (e_norm <= $signed(EW'(0))) begin
      norm_q = {sign_q, {(NEXP + NSIG){1'b0}}};
    end else begin
      norm_q = {sign_q, e_norm[NEXP-1:0], frac_n};
    end
  end

`ifdef FPDIV_RNE_ROUND_EN
  assign unused_pn = ^pn[PW-1:PW-2];
`else
  assign unused_pn = ^{pn[PW-1:PW-2], pn[F-1:0]};
`endif

  // FSM: state register, next-state logic, outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = special ? StDone : StRecip;
      StRecip: if (last_iter) state_d = StMul;
      StMul:   state_d = StNorm;
      StNorm:  state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = state_q == StIdle;
    out_valid = state_q == StDone;
  end

  // Datapath next-state.
  always_comb begin
    sign_d = sign_q;
    ea_d   = ea_q;
    eb_d   = eb_q;
    ma_d   = ma_q;
    mb_d   = mb_q;
    x_d    = x_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    q_d    = q_q;
    dbz_d  = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d = sign_in;
          ea_d   = exp_a;
          eb_d   = exp_b;
          ma_d   = {1'b1, frac_a};
          mb_d   = {1'b1, frac_b};
          // x0 = 1.5 - m_B/2 lands in (0.5, 1.0] and is exactly 1.0 for m_B == 1.0.
          x_d    = THREE_HALF - ({1'b1, frac_b, {GUARD{1'b0}}} >> 1);
          cnt_d  = '0;
          dbz_d  = 1'b0;
          if (special) begin
            q_d   = spec_q;
            dbz_d = spec_dbz;
          end
        end
      end
      StRecip: begin
        x_d   = x_next;
        cnt_d = last_iter ? '0 : cnt_q + CW'(1);
      end
      StMul:   p_d = {{(F + 1){1'b0}}, ma_q} * {{(NSIG + 1){1'b0}}, x_q};
      StNorm:  q_d = norm_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0;
      ea_q   <= '0;
      eb_q   <= '0;
      ma_q   <= '0;
      mb_q   <= '0;
      x_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      q_q    <= '0;
      dbz_q  <= 1'b0;
    end else begin
      sign_q <= sign_d;
      ea_q   <= ea_d;
      eb_q   <= eb_d;
      ma_q   <= ma_d;
      mb_q   <= mb_d;
      x_q    <= x_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      dbz_q  <= dbz_d;
    end
  end

  assign out_q   = q_q;
  assign out_dbz = dbz_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq (bfloat16): normal quotients, specials, range limits,
// output back-pressure and asynchronous reset mid-operation.
`timescale 1ns/1ps
module tb_fp_div_seq;

  localparam int unsigned NITER = 3;
  localparam int LAT = NITER + 3;

`ifdef FPDIV_RNE_ROUND_EN
  localparam logic [15:0] Q_1_3    = 16'h3EAB;
  localparam logic [15:0] Q_1_1P5  = 16'h3F2B;
  localparam logic [15:0] Q_1_1P25 = 16'h3F4D;
`else
  localparam logic [15:0] Q_1_3    = 16'h3EAA;
  localparam logic [15:0] Q_1_1P5  = 16'h3F2A;
  localparam logic [15:0] Q_1_1P25 = 16'h3F4C;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_q;
  logic        out_dbz;

  int n_tests  = 0;
  int n_failed = 0;

  fp_div_seq #(
    .NITER (NITER)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_dbz   (out_dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the accepting edge.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!out_valid && cycles < 40);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] q_exp, input logic dbz_exp, input int lat_exp);
    int cyc;
    check({tag, ":ready"}, 32'(in_ready), 32'd1);
    start(a, b);
    wait_valid(cyc);
    check({tag, ":lat"}, 32'(cyc), 32'(lat_exp));
    check({tag, ":q"}, 32'(out_q), 32'(q_exp));
    check({tag, ":dbz"}, 32'(out_dbz), 32'(dbz_exp));
    take();
    check({tag, ":taken"}, 32'({out_valid, in_ready}), 32'h1);
  endtask

  initial begin
    int cyc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    repeat (2) @(negedge clk);
    check("rst:in_ready", 32'(in_ready), 32'd1);
    check("rst:out_valid", 32'(out_valid), 32'd0);
    check("rst:out_q", 32'(out_q), 32'd0);
    check("rst:out_dbz", 32'(out_dbz), 32'd0);
    rst = 1'b0;

    run_op("6/2",      16'h40C0, 16'h4000, 16'h4040, 1'b0, LAT);
    run_op("1/3",      16'h3F80, 16'h4040, Q_1_3,    1'b0, LAT);
    run_op("1/1.5",    16'h3F80, 16'h3FC0, Q_1_1P5,  1'b0, LAT);
    run_op("1/1.25",   16'h3F80, 16'h3FA0, Q_1_1P25, 1'b0, LAT);
    run_op("8/4",      16'h4100, 16'h4080, 16'h4000, 1'b0, LAT);
    run_op("-2/2",     16'hC000, 16'h4000, 16'hBF80, 1'b0, LAT);
    run_op("ovf",      16'h7F00, 16'h0080, 16'h7F80, 1'b0, LAT);
    run_op("unf",      16'h0080, 16'h7F00, 16'h0000, 1'b0, LAT);
    run_op("1/0",      16'h3F80, 16'h0000, 16'h7F80, 1'b1, 1);
    run_op("-1/0",     16'hBF80, 16'h0000, 16'hFF80, 1'b1, 1);
    run_op("0/0",      16'h0000, 16'h0000, 16'h7FC0, 1'b0, 1);
    run_op("nan/2",    16'h7FC1, 16'h4000, 16'h7FC0, 1'b0, 1);
    run_op("inf/inf",  16'h7F80, 16'hFF80, 16'h7FC0, 1'b0, 1);
    run_op("inf/0",    16'h7F80, 16'h0000, 16'h7F80, 1'b0, 1);
    run_op("-inf/2",   16'hFF80, 16'h4000, 16'hFF80, 1'b0, 1);
    run_op("2/inf",    16'h4000, 16'h7F80, 16'h0000, 1'b0, 1);
    run_op("0/-2",     16'h0000, 16'hC000, 16'h8000, 1'b0, 1);
    run_op("sub/2",    16'h0040, 16'h4000, 16'h0000, 1'b0, 1);

    // Back-pressure: result held, no new operand accepted until the handshake.
    start(16'h40C0, 16'h4000);
    wait_valid(cyc);
    check("hold:lat", 32'(cyc), 32'(LAT));
    in_a     = 16'hC000;
    in_b     = 16'h4000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold:q", 32'(out_q), 32'h4040);
      check("hold:in_ready", 32'(in_ready), 32'd0);
      check("hold:out_valid", 32'(out_valid), 32'd1);
    end
    take();
    check("hold:idle_after_take", 32'({out_valid, in_ready}), 32'h1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("hold:next_accepted", 32'(in_ready), 32'd0);
    wait_valid(cyc);
    check("next:lat", 32'(cyc), 32'(LAT));
    check("next:q", 32'(out_q), 32'hBF80);
    take();

    // Asynchronous reset while iterating.
    start(16'h40C0, 16'h4000);
    @(negedge clk);
    check("abort:busy", 32'(in_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("abort:in_ready", 32'(in_ready), 32'd1);
    check("abort:out_valid", 32'(out_valid), 32'd0);
    #1 rst = 1'b0;
    run_op("post_rst", 16'h40C0, 16'h4000, 16'h4040, 1'b0, LAT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
